// File: rtl/hex_display_scan_if.sv
// Bundle between the datapath and the display scanner: load strobe and packed
// value inward, per-slot nibble, digit select and status outward.
interface hex_display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    lzb;
  logic [3:0]              hex_digit;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    blank;
  logic                    pending;
  logic                    frame_upd;

  modport master (
    output load, value_in, lzb,
    input  hex_digit, digit_sel, blank, pending, frame_upd
  );

  modport slave (
    input  load, value_in, lzb,
    output hex_digit, digit_sel, blank, pending, frame_upd
  );
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed scanner for a common-anode 7-segment display. New values
// wait in a shadow register and only reach the display at a frame boundary.
module hex_display_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000
) (
  input logic clk,
  input logic rst,
  hex_display_scan_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] disp;
  logic                    pending_q;
  logic                    frame_upd_q;
  logic                    tick;
  logic                    boundary;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic [3:0]              nib;
  logic                    lead_zero;
  logic                    blank_c;

  assign tick     = (cnt == CNT_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  // A load landing on the boundary edge is written after the commit so the
  // commit sees the old shadow while the new value stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      disp        <= '0;
      pending_q   <= 1'b0;
      frame_upd_q <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= boundary ? '0 : idx + 1'b1;
      end
      frame_upd_q <= 1'b0;
      if (boundary && pending_q) begin
        disp        <= shadow;
        pending_q   <= 1'b0;
        frame_upd_q <= 1'b1;
      end
      if (bus.load) begin
        shadow    <= bus.value_in;
        pending_q <= 1'b1;
      end
    end
  end

  // zero_from[k] is set when every nibble from digit k up to the top is zero.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_zero
    assign zero_from[k] = ~|disp[4*NUM_DIGITS-1 : 4*k];
  end

  always_comb begin
    nib       = 4'h0;
    lead_zero = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib       = disp[4*k +: 4];
        lead_zero = zero_from[k];
      end
    end
  end

  assign blank_c = bus.lzb && (idx != '0) && lead_zero;

  assign bus.blank     = blank_c;
  assign bus.hex_digit = blank_c ? 4'h0 : nib;
  assign bus.digit_sel = blank_c ? '1 : ~(NUM_DIGITS'(1) << idx);
  assign bus.pending   = pending_q;
  assign bus.frame_upd = frame_upd_q;
endmodule
